// File: rtl/gate_tester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gate_tester                                                  |
// | Description : Exhaustive 2-input gate tester. Walks vectors 00..11, holds  |
// |               each for SETTLE cycles, compares dut_y with the expected     |
// |               value for the requested gate and reports per-vector fails.   |
// |               Optional macro GATE_TESTER_ABORT_EN: stop at first mismatch. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module gate_tester #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op,
  input  logic       dut_y,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    FIN   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_HOLD = 4'(SETTLE - 1);
  localparam logic [2:0] ERR_MAX   = 3'd4;

  state_t     state;
  logic [2:0] op_q;
  logic [1:0] vec;
  logic [3:0] settle_cnt;

  logic       expected_y;
  logic       mismatch;
  logic       abort_hit;
  logic       last_vec;
  logic [2:0] err_next;
  logic [3:0] fail_next;

  function automatic logic gate_ref(input logic [2:0] g, input logic a, input logic b);
    case (g)
      3'd0:    gate_ref = a & b;
      3'd1:    gate_ref = a | b;
      3'd2:    gate_ref = a ^ b;
      3'd3:    gate_ref = ~(a & b);
      3'd4:    gate_ref = ~(a | b);
      3'd5:    gate_ref = ~(a ^ b);
      default: gate_ref = 1'b0;
    endcase
  endfunction

  always_comb begin
    expected_y = gate_ref(op_q, vec[1], vec[0]);
    mismatch   = (dut_y != expected_y);
    last_vec   = (vec == 2'd3);
    err_next   = err_count;
    fail_next  = fail_vec;
    if (mismatch) begin
      fail_next = fail_vec | (4'b0001 << vec);
      if (err_count != ERR_MAX) begin
        err_next = err_count + 3'd1;
      end
    end
  end

`ifdef GATE_TESTER_ABORT_EN
  assign abort_hit = mismatch;
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= 3'd0;
      vec        <= 2'd0;
      settle_cnt <= 4'd0;
      dut_a      <= 1'b0;
      dut_b      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 3'd0;
      fail_vec   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q       <= op;
            pass       <= 1'b0;
            err_count  <= 3'd0;
            fail_vec   <= 4'd0;
            vec        <= 2'd0;
            settle_cnt <= 4'd0;
            dut_a      <= 1'b0;
            dut_b      <= 1'b0;
            // Ops 6 and 7 skip the sweep entirely and report a failed run.
            if (op > 3'd5) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= DRIVE;
              busy  <= 1'b1;
            end
          end
        end

        DRIVE: begin
          if (settle_cnt == LAST_HOLD) begin
            err_count  <= err_next;
            fail_vec   <= fail_next;
            settle_cnt <= 4'd0;
            if (last_vec || abort_hit) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
              dut_a <= 1'b0;
              dut_b <= 1'b0;
              pass  <= (err_next == 3'd0);
            end else begin
              vec            <= vec + 2'd1;
              {dut_a, dut_b} <= vec + 2'd1;
            end
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end

        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
